sr_ff_monitor: RTL and testbench

//   Synthesizable receiving-end checker for the clocked SR flip-flop command stream.

---
 rtl/sr_ff_monitor.sv | 145 ++++++++++++++
 tb/tb_sr_ff_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_monitor.sv
// Receiving-end checker for a clocked SR flip-flop: tracks a reference Q from the
// sampled S/R stream, flags Q/Qbar disagreements and S=R=1 commands, and counts events.
module sr_ff_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Qbar,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             forbidden,
  output logic             err_sticky,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] forb_cnt
);

  typedef enum logic [1:0] {
    ST_UNK   = 2'b00,
    ST_TRACK = 2'b01,
    ST_FAIL  = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             exp_q_d;
  logic             exp_valid_d;
  logic             mismatch_d;
  logic             forbidden_d;
  logic             sticky_d;
  logic             check_err_c;
  logic [CNT_W-1:0] set_d;
  logic [CNT_W-1:0] rst_d;
  logic [CNT_W-1:0] mis_d;
  logic [CNT_W-1:0] forb_d;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, model and event logic; clr overrides en, FAIL freezes everything.
  always_comb begin
    state_d     = state_q;
    exp_q_d     = exp_q;
    mismatch_d  = 1'b0;
    forbidden_d = 1'b0;
    sticky_d    = err_sticky;
    set_d       = set_cnt;
    rst_d       = rst_cnt;
    mis_d       = mis_cnt;
    forb_d      = forb_cnt;
    check_err_c = 1'b0;

    if (clr) begin
      state_d  = ST_UNK;
      exp_q_d  = 1'b0;
      sticky_d = 1'b0;
      set_d    = '0;
      rst_d    = '0;
      mis_d    = '0;
      forb_d   = '0;
    end else if (en && (state_q != ST_FAIL)) begin
      // Q here is the DUT's response to the command sampled on the previous edge.
      check_err_c = (state_q == ST_TRACK) && ((Q != exp_q) || (Q == Qbar));
      mismatch_d  = check_err_c;
      forbidden_d = S & R;

      if (S & ~R) set_d  = sat_inc(set_cnt);
      if (~S & R) rst_d  = sat_inc(rst_cnt);
      if (S & R)  forb_d = sat_inc(forb_cnt);
      if (check_err_c) begin
        mis_d    = sat_inc(mis_cnt);
        sticky_d = 1'b1;
      end

      case (state_q)
        ST_UNK: begin
          if (S & ~R) begin
            exp_q_d = 1'b1;
            state_d = ST_TRACK;
          end else if (~S & R) begin
            exp_q_d = 1'b0;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (check_err_c && STOP_ON_ERR) begin
            state_d = ST_FAIL;
          end else if (S & R) begin
            state_d = ST_UNK;
            exp_q_d = 1'b0;
          end else if (S) begin
            exp_q_d = 1'b1;
          end else if (R) begin
            exp_q_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end

    exp_valid_d = (state_d == ST_TRACK);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= ST_UNK;
      exp_q      <= 1'b0;
      exp_valid  <= 1'b0;
      mismatch   <= 1'b0;
      forbidden  <= 1'b0;
      err_sticky <= 1'b0;
      set_cnt    <= '0;
      rst_cnt    <= '0;
      mis_cnt    <= '0;
      forb_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_q_d;
      exp_valid  <= exp_valid_d;
      mismatch   <= mismatch_d;
      forbidden  <= forbidden_d;
      err_sticky <= sticky_d;
      set_cnt    <= set_d;
      rst_cnt    <= rst_d;
      mis_cnt    <= mis_d;
      forb_cnt   <= forb_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Directed bench for sr_ff_monitor: three parameterisations share one S/R stream
// driven into a behavioural SR flip-flop with injectable output faults.
module tb_sr_ff_monitor;

  localparam int EXPQ = 0, EXPV = 1, MIS = 2, FORB = 3, STICKY = 4;
  localparam int STATE = 5, SETC = 6, RSTC = 7, MISC = 8, FORBC = 9;
  localparam int DA = 0, DB = 1, DC = 2;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic S = 1'b0;
  logic R = 1'b0;
  logic Q, Qbar;
  logic ff_q;
  logic fault_en = 1'b0;
  logic fault_q = 1'b0;
  logic fault_qbar = 1'b0;

  logic       a_exp_q, a_exp_valid, a_mismatch, a_forbidden, a_err_sticky;
  logic [1:0] a_state;
  logic [7:0] a_set_cnt, a_rst_cnt, a_mis_cnt, a_forb_cnt;
  logic       b_exp_q, b_exp_valid, b_mismatch, b_forbidden, b_err_sticky;
  logic [1:0] b_state;
  logic [7:0] b_set_cnt, b_rst_cnt, b_mis_cnt, b_forb_cnt;
  logic       c_exp_q, c_exp_valid, c_mismatch, c_forbidden, c_err_sticky;
  logic [1:0] c_state;
  logic [1:0] c_set_cnt, c_rst_cnt, c_mis_cnt, c_forb_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          d;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  // Behavioural SR flip-flop standing in for the monitored device.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst)          ff_q <= 1'b0;
    else if (S & ~R)  ff_q <= 1'b1;
    else if (~S & R)  ff_q <= 1'b0;
  end

  assign Q    = fault_en ? fault_q    : ff_q;
  assign Qbar = fault_en ? fault_qbar : ~ff_q;

  sr_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut_a (
    .CLK(CLK), .rst(rst), .en(en), .clr(clr), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .exp_q(a_exp_q), .exp_valid(a_exp_valid), .mismatch(a_mismatch),
    .forbidden(a_forbidden), .err_sticky(a_err_sticky), .state(a_state),
    .set_cnt(a_set_cnt), .rst_cnt(a_rst_cnt), .mis_cnt(a_mis_cnt), .forb_cnt(a_forb_cnt)
  );

  sr_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut_b (
    .CLK(CLK), .rst(rst), .en(en), .clr(clr), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .exp_q(b_exp_q), .exp_valid(b_exp_valid), .mismatch(b_mismatch),
    .forbidden(b_forbidden), .err_sticky(b_err_sticky), .state(b_state),
    .set_cnt(b_set_cnt), .rst_cnt(b_rst_cnt), .mis_cnt(b_mis_cnt), .forb_cnt(b_forb_cnt)
  );

  sr_ff_monitor #(.CNT_W(2), .STOP_ON_ERR(1'b1)) dut_c (
    .CLK(CLK), .rst(rst), .en(en), .clr(clr), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
    .exp_q(c_exp_q), .exp_valid(c_exp_valid), .mismatch(c_mismatch),
    .forbidden(c_forbidden), .err_sticky(c_err_sticky), .state(c_state),
    .set_cnt(c_set_cnt), .rst_cnt(c_rst_cnt), .mis_cnt(c_mis_cnt), .forb_cnt(c_forb_cnt)
  );

  function automatic logic [31:0] pick(input int d, input logic [31:0] va,
                                       input logic [31:0] vb, input logic [31:0] vc);
    return (d == DA) ? va : ((d == DB) ? vb : vc);
  endfunction

  function automatic logic [31:0] observe(input int d, input int sig);
    case (sig)
      EXPQ:    return pick(d, 32'(a_exp_q), 32'(b_exp_q), 32'(c_exp_q));
      EXPV:    return pick(d, 32'(a_exp_valid), 32'(b_exp_valid), 32'(c_exp_valid));
      MIS:     return pick(d, 32'(a_mismatch), 32'(b_mismatch), 32'(c_mismatch));
      FORB:    return pick(d, 32'(a_forbidden), 32'(b_forbidden), 32'(c_forbidden));
      STICKY:  return pick(d, 32'(a_err_sticky), 32'(b_err_sticky), 32'(c_err_sticky));
      STATE:   return pick(d, 32'(a_state), 32'(b_state), 32'(c_state));
      SETC:    return pick(d, 32'(a_set_cnt), 32'(b_set_cnt), 32'(c_set_cnt));
      RSTC:    return pick(d, 32'(a_rst_cnt), 32'(b_rst_cnt), 32'(c_rst_cnt));
      MISC:    return pick(d, 32'(a_mis_cnt), 32'(b_mis_cnt), 32'(c_mis_cnt));
      FORBC:   return pick(d, 32'(a_forb_cnt), 32'(b_forb_cnt), 32'(c_forb_cnt));
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic ex(input string tag, input int d, input int sig, input int unsigned val);
    exp_t e;
    e.tag = tag;
    e.d   = d;
    e.sig = sig;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.d, e.sig);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s dut=%0d sig=%0d observed=%0h expected=%0h", e.tag, e.d, e.sig, obs, e.val);
      end
    end
  endtask

  // One clock: drive S/R, let the edge happen, then compare what was queued.
  task automatic cyc(input logic s, input logic r);
    S = s;
    R = r;
    @(posedge CLK);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 3; d++)
      for (int s = 0; s < 10; s++) ex("reset_state", d, s, 0);
    drain();
    rst = 1'b0;

    // Correct device, set twice, hold, reset twice, hold
    ex("t2_state", DA, STATE, 1); ex("t2_expq", DA, EXPQ, 1); ex("t2_expv", DA, EXPV, 1);
    ex("t2_set1", DA, SETC, 1); ex("t2_mis", DA, MIS, 0);
    cyc(1'b1, 1'b0);
    ex("t2_mis", DA, MIS, 0); ex("t2_set2", DA, SETC, 2);
    cyc(1'b1, 1'b0);
    ex("t2_mis", DA, MIS, 0); ex("t2_hold1", DA, EXPQ, 1);
    cyc(1'b0, 1'b0);
    ex("t2_mis", DA, MIS, 0); ex("t2_expq0", DA, EXPQ, 0); ex("t2_rst1", DA, RSTC, 1);
    cyc(1'b0, 1'b1);
    ex("t2_mis", DA, MIS, 0); ex("t2_rst2", DA, RSTC, 2);
    cyc(1'b0, 1'b1);
    ex("t2_fin_set", DA, SETC, 2); ex("t2_fin_rst", DA, RSTC, 2); ex("t2_fin_mis", DA, MISC, 0);
    ex("t2_fin_expq", DA, EXPQ, 0); ex("t2_fin_state", DA, STATE, 1);
    ex("t2_b_state", DB, STATE, 1); ex("t2_c_set", DC, SETC, 2);
    cyc(1'b0, 1'b0);

    // Asynchronous reset in mid-cycle
    #2;
    rst = 1'b1;
    #1;
    for (int s = 0; s < 10; s++) ex("t1_async_rst", DA, s, 0);
    drain();
    #2;
    rst = 1'b0;
    ex("t1_post_state", DA, STATE, 0); ex("t1_post_expv", DA, EXPV, 0);
    cyc(1'b0, 1'b0);

    // Forbidden command while tracking
    ex("t3_state", DA, STATE, 1); ex("t3_expq", DA, EXPQ, 1); ex("t3_set", DA, SETC, 1);
    cyc(1'b1, 1'b0);
    ex("t3_forb", DA, FORB, 1); ex("t3_forbc", DA, FORBC, 1); ex("t3_unk", DA, STATE, 0);
    ex("t3_expv", DA, EXPV, 0); ex("t3_expq0", DA, EXPQ, 0); ex("t3_mis", DA, MIS, 0);
    ex("t3_b_forb", DB, FORB, 1);
    cyc(1'b1, 1'b1);
    ex("t3_forb_end", DA, FORB, 0); ex("t3_forbc_hold", DA, FORBC, 1); ex("t3_still_unk", DA, STATE, 0);
    cyc(1'b0, 1'b0);

    // Stuck-low Q after a set, stop-on-error variant freezes
    ex("t4_track", DA, STATE, 1); ex("t4_expq", DA, EXPQ, 1); ex("t4_set", DA, SETC, 2);
    cyc(1'b1, 1'b0);
    fault_en = 1'b1; fault_q = 1'b0; fault_qbar = 1'b1;
    ex("t4_mis", DA, MIS, 1); ex("t4_misc", DA, MISC, 1); ex("t4_sticky", DA, STICKY, 1);
    ex("t4_fail", DA, STATE, 2); ex("t4_expv", DA, EXPV, 0); ex("t4_set_hold", DA, SETC, 2);
    ex("t4_c_fail", DC, STATE, 2);
    cyc(1'b0, 1'b0);
    ex("t4_mis_end", DA, MIS, 0); ex("t4_frz_set", DA, SETC, 2); ex("t4_frz_state", DA, STATE, 2);
    cyc(1'b1, 1'b0);
    ex("t4_frz_rst", DA, RSTC, 0); ex("t4_frz_misc", DA, MISC, 1); ex("t4_frz_mis", DA, MIS, 0);
    cyc(1'b0, 1'b1);
    ex("t4_frz_forb", DA, FORB, 0); ex("t4_frz_forbc", DA, FORBC, 1); ex("t4_sticky_hold", DA, STICKY, 1);
    cyc(1'b1, 1'b1);

    // Synchronous clear while disabled
    fault_en = 1'b0; en = 1'b0; clr = 1'b1;
    ex("clr_state", DA, STATE, 0); ex("clr_sticky", DA, STICKY, 0); ex("clr_misc", DA, MISC, 0);
    ex("clr_set", DA, SETC, 0); ex("clr_forbc", DA, FORBC, 0); ex("clr_expq", DA, EXPQ, 0);
    ex("clr_b_sticky", DB, STICKY, 0); ex("clr_b_misc", DB, MISC, 0);
    cyc(1'b0, 1'b0);
    clr = 1'b0; en = 1'b1;

    // Q==Qbar fault, keep-tracking variant
    ex("t5_track", DB, STATE, 1); ex("t5_expq", DB, EXPQ, 1);
    cyc(1'b1, 1'b0);
    fault_en = 1'b1; fault_q = 1'b1; fault_qbar = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      ex("t5_mis", DB, MIS, 1); ex("t5_misc", DB, MISC, k);
      ex("t5_state", DB, STATE, 1); ex("t5_expv", DB, EXPV, 1);
      if (k == 1) ex("t5_a_fail", DA, STATE, 2);
      if (k == 3) ex("t5_sticky", DB, STICKY, 1);
      cyc(1'b0, 1'b0);
    end

    // Two-bit counters saturate
    fault_en = 1'b0; clr = 1'b1;
    ex("t6_clr_set", DC, SETC, 0); ex("t6_clr_state", DC, STATE, 0); ex("t6_clr_misc", DC, MISC, 0);
    cyc(1'b0, 1'b0);
    clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      ex("t6_sat", DC, SETC, (k > 3) ? 3 : k); ex("t6_mis", DC, MIS, 0); ex("t6_state", DC, STATE, 1);
      cyc(1'b1, 1'b0);
    end

    // Disabled monitor holds and suppresses pulses
    en = 1'b0;
    ex("en0_expq", DC, EXPQ, 1); ex("en0_rst", DC, RSTC, 0); ex("en0_state", DC, STATE, 1);
    cyc(1'b0, 1'b1);
    ex("en0_forb", DC, FORB, 0); ex("en0_forbc", DC, FORBC, 0); ex("en0_set", DC, SETC, 3);
    cyc(1'b1, 1'b1);
    clr = 1'b1;
    ex("t6_clr2_set", DC, SETC, 0); ex("t6_clr2_state", DC, STATE, 0);
    ex("t6_clr2_expq", DC, EXPQ, 0); ex("t6_clr2_expv", DC, EXPV, 0);
    cyc(1'b1, 1'b0);
    clr = 1'b0; en = 1'b1;

    // Mismatch and forbidden on the same edge
    ex("t7_track", DA, STATE, 1);
    cyc(1'b1, 1'b0);
    fault_en = 1'b1; fault_q = 1'b0; fault_qbar = 1'b1;
    ex("t7_a_mis", DA, MIS, 1); ex("t7_a_forb", DA, FORB, 1); ex("t7_a_misc", DA, MISC, 1);
    ex("t7_a_forbc", DA, FORBC, 1); ex("t7_a_fail", DA, STATE, 2);
    ex("t7_b_mis", DB, MIS, 1); ex("t7_b_forb", DB, FORB, 1);
    ex("t7_b_unk", DB, STATE, 0); ex("t7_b_expq", DB, EXPQ, 0);
    cyc(1'b1, 1'b1);
    fault_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
